mem_wb_stage: RTL

- Memory-access and write-back end of the MIPS pipeline. Consumes the registered EX/MEM outputs (ALU result, store data, destination register, RegWrite/memWrite/memRead/memtoReg).
- Drives a variable-latency data-memory request/acknowledge port and stalls upstream stages while an access is outstanding.
- Holds the MEM/WB pipeline register and produces the write-back triple (wb_reg_write, wb_rd, wb_data). The register file and the EX forwarding comparators use this triple.

---
 rtl/mem_wb_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// Memory-access and write-back stage: variable-latency data-memory handshake,
// upstream stall generation and the MEM/WB pipeline register.
module mem_wb_stage #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_write_data,
    input  logic [REG_W-1:0]  reg_write_dst,
    input  logic              ex_reg_write,
    input  logic              ex_mem_write,
    input  logic              ex_mem_read,
    input  logic              ex_memto_reg,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_timeout
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     cnt;
    logic              access;
    logic              limit;
    logic [REG_W-1:0]  p_rd;
    logic              p_rw;
    logic              p_m2r;
    logic              wb_m2r;
    logic [DATA_W-1:0] wb_alu;
    logic [DATA_W-1:0] wb_mem;

    assign access = ex_mem_read | ex_mem_write;
    assign limit  = (cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    state_nx = BUSY;
                    stall    = 1'b1;
                end
            end
            BUSY: begin
                if (mem_ack || limit) state_nx = IDLE;
                else                  stall    = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // mem_addr doubles as the latched ALU result for the write-back mux
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cnt          <= '0;
            mem_timeout  <= 1'b0;
            p_rd         <= '0;
            p_rw         <= 1'b0;
            p_m2r        <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_m2r       <= 1'b0;
            wb_alu       <= '0;
            wb_mem       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        mem_req      <= 1'b1;
                        mem_we       <= ex_mem_write;
                        mem_addr     <= alu_result;
                        mem_wdata    <= mem_write_data;
                        p_rd         <= reg_write_dst;
                        p_rw         <= ex_reg_write;
                        p_m2r        <= ex_memto_reg;
                        cnt          <= '0;
                        wb_reg_write <= 1'b0;
                    end else begin
                        wb_reg_write <= ex_reg_write && (reg_write_dst != '0);
                        wb_rd        <= reg_write_dst;
                        wb_alu       <= alu_result;
                        wb_m2r       <= 1'b0;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req      <= 1'b0;
                        wb_reg_write <= p_rw && (p_rd != '0);
                        wb_rd        <= p_rd;
                        wb_m2r       <= p_m2r;
                        wb_alu       <= mem_addr;
                        wb_mem       <= mem_rdata;
                    end else if (limit) begin
                        mem_timeout  <= 1'b1;
                        mem_req      <= 1'b0;
                        wb_reg_write <= 1'b0;
                    end else begin
                        cnt          <= cnt + CW'(1);
                        wb_reg_write <= 1'b0;
                    end
                end
                default: mem_req <= 1'b0;
            endcase
        end
    end

    assign wb_data = wb_m2r ? wb_mem : wb_alu;

endmodule
